// File: rtl/hex_display_reader.sv
// Reading end of the four-digit seven-segment display. Waits until the display has been
// stable, decodes it to BCD/blank, and offers the result on a valid/ready port.
module hex_display_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk100_i,
    input  logic        rst_i,
    input  logic [6:0]  hex0_i,
    input  logic [6:0]  hex1_i,
    input  logic [6:0]  hex2_i,
    input  logic [6:0]  hex3_i,
    input  logic        ready_i,
    output logic [15:0] value_o,
    output logic [3:0]  blank_o,
    output logic        valid_o,
    output logic        overrun_o,
    output logic        err_o,
    output logic [3:0]  err_mask_o,
    output logic [15:0] update_cnt_o
);

    localparam logic [7:0] STABLE_SAT  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    // Active-low segment code to {invalid, blank, bcd}; blank and invalid digits read as 4'hF.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] res;
        case (seg)
            7'h40:   res = 6'b00_0000;
            7'h79:   res = 6'b00_0001;
            7'h24:   res = 6'b00_0010;
            7'h30:   res = 6'b00_0011;
            7'h19:   res = 6'b00_0100;
            7'h12:   res = 6'b00_0101;
            7'h02:   res = 6'b00_0110;
            7'h78:   res = 6'b00_0111;
            7'h00:   res = 6'b00_1000;
            7'h10:   res = 6'b00_1001;
            7'h7F:   res = 6'b01_1111;
            default: res = 6'b10_1111;
        endcase
        return res;
    endfunction

    logic [27:0] sample_s;
    logic [27:0] s_q_r;
    logic [7:0]  cnt_r;
    logic        published_r;
    logic        match_s;
    logic        publish_pt_s;
    logic [5:0]  dec_s [4];
    logic [15:0] digits_s;
    logic [3:0]  blank_s;
    logic [3:0]  invalid_s;
    logic        changed_s;
    logic        do_pub_s;
    logic        do_err_s;

    assign sample_s = {hex3_i, hex2_i, hex1_i, hex0_i};

    for (genvar g = 0; g < 4; g++) begin : g_dec
        assign dec_s[g]           = decode_seg(s_q_r[7*g +: 7]);
        assign digits_s[4*g +: 4] = dec_s[g][3:0];
        assign blank_s[g]         = dec_s[g][4];
        assign invalid_s[g]       = dec_s[g][5];
    end

    // Publish-point qualification: decode comes from the held sample, not the live input.
    always_comb begin
        match_s      = (sample_s == s_q_r);
        publish_pt_s = match_s && (cnt_r == STABLE_LAST);
        // value_o/blank_o only ever change on a publish, so they double as the last result.
        changed_s    = !published_r || ({digits_s, blank_s} != {value_o, blank_o});
        if (publish_pt_s) begin
            do_err_s = (invalid_s != 4'b0000);
            do_pub_s = (invalid_s == 4'b0000) && changed_s;
        end else begin
            do_err_s = 1'b0;
            do_pub_s = 1'b0;
        end
    end

    // Sample register and saturating stability counter.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            s_q_r <= {4{7'h7F}};
            cnt_r <= 8'd0;
        end else begin
            s_q_r <= sample_s;
            if (!match_s) begin
                cnt_r <= 8'd0;
            end else if (cnt_r != STABLE_SAT) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Published result, handshake and sticky overrun.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            value_o      <= 16'h0000;
            blank_o      <= 4'hF;
            valid_o      <= 1'b0;
            overrun_o    <= 1'b0;
            published_r  <= 1'b0;
            update_cnt_o <= 16'h0000;
        end else if (do_pub_s) begin
            value_o      <= digits_s;
            blank_o      <= blank_s;
            valid_o      <= 1'b1;
            published_r  <= 1'b1;
            update_cnt_o <= update_cnt_o + 16'd1;
            // A simultaneous transfer consumes the old value, so that is not an overrun.
            if (valid_o && !ready_i) begin
                overrun_o <= 1'b1;
            end else begin
                overrun_o <= overrun_o;
            end
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_o;
        end
    end

    // Error pulse and the invalid-digit mask that caused it.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            err_o      <= 1'b0;
            err_mask_o <= 4'b0000;
        end else begin
            err_o <= do_err_s;
            if (do_err_s) begin
                err_mask_o <= invalid_s;
            end else begin
                err_mask_o <= err_mask_o;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_reader.sv
// Directed bench for hex_display_reader with STABLE_CYCLES = 4.
module tb_hex_display_reader;

    localparam logic [6:0] BL = 7'h7F;

    logic        clk100_i = 1'b0;
    logic        rst_i    = 1'b1;
    logic [6:0]  hex0_i   = BL;
    logic [6:0]  hex1_i   = BL;
    logic [6:0]  hex2_i   = BL;
    logic [6:0]  hex3_i   = BL;
    logic        ready_i  = 1'b1;
    logic [15:0] value_o;
    logic [3:0]  blank_o;
    logic        valid_o;
    logic        overrun_o;
    logic        err_o;
    logic [3:0]  err_mask_o;
    logic [15:0] update_cnt_o;

    int vectors = 0;
    int fails   = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    hex_display_reader #(.STABLE_CYCLES(4)) dut (
        .clk100_i(clk100_i), .rst_i(rst_i),
        .hex0_i(hex0_i), .hex1_i(hex1_i), .hex2_i(hex2_i), .hex3_i(hex3_i),
        .ready_i(ready_i), .value_o(value_o), .blank_o(blank_o), .valid_o(valid_o),
        .overrun_o(overrun_o), .err_o(err_o), .err_mask_o(err_mask_o),
        .update_cnt_o(update_cnt_o)
    );

    always #5 clk100_i = ~clk100_i;

    task automatic step(input int n);
        repeat (n) @(posedge clk100_i);
        #1;
    endtask

    task automatic set_hex(input logic [6:0] h3, input logic [6:0] h2,
                           input logic [6:0] h1, input logic [6:0] h0);
        hex3_i = h3; hex2_i = h2; hex1_i = h1; hex0_i = h0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; ready_i = 1'b1;
        set_hex(BL, BL, BL, BL);
        step(2);
        vectors++; if (value_o !== 16'h0000) begin fails++; $display("FAIL reset_value got %h exp 0000", value_o); end
        vectors++; if (blank_o !== 4'hF) begin fails++; $display("FAIL reset_blank got %h exp F", blank_o); end
        vectors++; if ({valid_o, overrun_o, err_o} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {valid_o, overrun_o, err_o}); end
        vectors++; if (err_mask_o !== 4'h0) begin fails++; $display("FAIL reset_mask got %h exp 0", err_mask_o); end
        vectors++; if (update_cnt_o !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", update_cnt_o); end
    endtask

    task automatic test_first_publish();
        set_hex(7'h40, 7'h40, 7'h40, 7'h40);
        rst_i = 1'b0;
        step(4);
        vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL first_early got %b exp 0", valid_o); end
        step(1);
        vectors++; if (valid_o !== 1'b1) begin fails++; $display("FAIL first_valid got %b exp 1", valid_o); end
        vectors++; if (value_o !== 16'h0000) begin fails++; $display("FAIL first_value got %h exp 0000", value_o); end
        vectors++; if (blank_o !== 4'h0) begin fails++; $display("FAIL first_blank got %h exp 0", blank_o); end
        vectors++; if (update_cnt_o !== 16'd1) begin fails++; $display("FAIL first_cnt got %0d exp 1", update_cnt_o); end
        step(1);
        vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL first_clear got %b exp 0", valid_o); end
        step(4);
        vectors++; if (update_cnt_o !== 16'd1) begin fails++; $display("FAIL first_once got %0d exp 1", update_cnt_o); end
    endtask

    task automatic test_glitch();
        set_hex(7'h40, 7'h40, 7'h40, 7'h79);
        step(3);
        set_hex(7'h40, 7'h40, 7'h40, 7'h40);
        step(8);
        vectors++; if ({valid_o, update_cnt_o} !== {1'b0, 16'd1}) begin fails++; $display("FAIL glitch_nopub got valid %b cnt %0d exp 0/1", valid_o, update_cnt_o); end
        set_hex(7'h40, 7'h40, 7'h40, 7'h79);
        step(4);
        vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL glitch_early got %b exp 0", valid_o); end
        step(1);
        vectors++; if (value_o !== 16'h0001) begin fails++; $display("FAIL glitch_value got %h exp 0001", value_o); end
        vectors++; if (update_cnt_o !== 16'd2) begin fails++; $display("FAIL glitch_cnt got %0d exp 2", update_cnt_o); end
        step(1);
        vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL glitch_clear got %b exp 0", valid_o); end
    endtask

    task automatic test_error();
        set_hex(7'h40, 7'h7E, 7'h40, 7'h79);
        step(4);
        vectors++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_early got %b exp 0", err_o); end
        step(1);
        vectors++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_pulse got %b exp 1", err_o); end
        vectors++; if (err_mask_o !== 4'b0100) begin fails++; $display("FAIL err_mask got %b exp 0100", err_mask_o); end
        vectors++; if ({valid_o, value_o} !== {1'b0, 16'h0001}) begin fails++; $display("FAIL err_hold got valid %b value %h exp 0/0001", valid_o, value_o); end
        step(1);
        vectors++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_width got %b exp 0", err_o); end
        step(3);
        vectors++; if ({err_o, err_mask_o, update_cnt_o} !== {1'b0, 4'b0100, 16'd2}) begin fails++; $display("FAIL err_once got err %b mask %b cnt %0d exp 0/0100/2", err_o, err_mask_o, update_cnt_o); end
    endtask

    task automatic test_overrun();
        ready_i = 1'b0;
        set_hex(7'h40, 7'h40, 7'h79, 7'h24);
        step(5);
        vectors++; if ({valid_o, value_o, overrun_o} !== {1'b1, 16'h0012, 1'b0}) begin fails++; $display("FAIL ovr_first got valid %b value %h ovr %b exp 1/0012/0", valid_o, value_o, overrun_o); end
        set_hex(7'h40, 7'h40, 7'h79, 7'h30);
        step(5);
        vectors++; if (value_o !== 16'h0013) begin fails++; $display("FAIL ovr_value got %h exp 0013", value_o); end
        vectors++; if ({valid_o, overrun_o} !== 2'b11) begin fails++; $display("FAIL ovr_flag got %b exp 11", {valid_o, overrun_o}); end
        vectors++; if (update_cnt_o !== 16'd4) begin fails++; $display("FAIL ovr_cnt got %0d exp 4", update_cnt_o); end
        ready_i = 1'b1;
        step(1);
        vectors++; if ({valid_o, overrun_o} !== 2'b01) begin fails++; $display("FAIL ovr_drain got %b exp 01", {valid_o, overrun_o}); end
    endtask

    task automatic test_reset_mid_episode();
        ready_i = 1'b0;
        set_hex(7'h40, 7'h40, 7'h40, 7'h79);
        step(3);
        rst_i = 1'b1;
        step(1);
        vectors++; if ({valid_o, overrun_o, err_o, err_mask_o} !== 7'b0) begin fails++; $display("FAIL mid_flags got %b exp 0000000", {valid_o, overrun_o, err_o, err_mask_o}); end
        vectors++; if ({value_o, blank_o, update_cnt_o} !== {16'h0000, 4'hF, 16'd0}) begin fails++; $display("FAIL mid_regs got %h/%h/%0d exp 0000/F/0", value_o, blank_o, update_cnt_o); end
        rst_i = 1'b0;
        step(4);
        vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL mid_early got %b exp 0", valid_o); end
        step(1);
        vectors++; if ({valid_o, value_o, update_cnt_o} !== {1'b1, 16'h0001, 16'd1}) begin fails++; $display("FAIL mid_pub got valid %b value %h cnt %0d exp 1/0001/1", valid_o, value_o, update_cnt_o); end
    endtask

    task automatic test_back_to_back();
        set_hex(7'h40, 7'h40, 7'h40, 7'h24);
        step(4);
        ready_i = 1'b1;
        step(1);
        vectors++; if ({valid_o, value_o, overrun_o} !== {1'b1, 16'h0002, 1'b0}) begin fails++; $display("FAIL b2b_collide got valid %b value %h ovr %b exp 1/0002/0", valid_o, value_o, overrun_o); end
        step(1);
        vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL b2b_clear got %b exp 0", valid_o); end
    endtask

    task automatic test_stopwatch();
        logic [3:0] dn;
        ready_i = 1'b1;
        rst_i = 1'b1;
        step(2);
        for (int d = 0; d < 10; d++) begin
            dn = d[3:0];
            set_hex(BL, BL, BL, seg_tab[d]);
            rst_i = 1'b0;
            step(5);
            vectors++; if ({valid_o, value_o, blank_o} !== {1'b1, 12'hFFF, dn, 4'b1110}) begin fails++; $display("FAIL sw_digit%0d got valid %b value %h blank %b", d, valid_o, value_o, blank_o); end
            step(1);
            vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL sw_clear%0d got %b exp 0", d, valid_o); end
        end
        vectors++; if (update_cnt_o !== 16'd10) begin fails++; $display("FAIL sw_cnt got %0d exp 10", update_cnt_o); end
        vectors++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL sw_ovr got %b exp 0", overrun_o); end
    endtask

    task automatic test_blank_after_reset();
        rst_i = 1'b1;
        set_hex(BL, BL, BL, BL);
        step(2);
        rst_i = 1'b0;
        step(3);
        vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL blank_early got %b exp 0", valid_o); end
        step(1);
        vectors++; if ({valid_o, value_o, blank_o, update_cnt_o} !== {1'b1, 16'hFFFF, 4'hF, 16'd1}) begin fails++; $display("FAIL blank_pub got valid %b value %h blank %h cnt %0d exp 1/FFFF/F/1", valid_o, value_o, blank_o, update_cnt_o); end
        step(6);
        vectors++; if ({valid_o, update_cnt_o} !== {1'b0, 16'd1}) begin fails++; $display("FAIL blank_once got valid %b cnt %0d exp 0/1", valid_o, update_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_first_publish();
        test_glitch();
        test_error();
        test_overrun();
        test_reset_mid_episode();
        test_back_to_back();
        test_stopwatch();
        test_blank_after_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/hex_display_reader.md
# hex_display_reader

Monitor block for the lab's four-digit seven-segment display. It samples the four active-low segment buses driven by the stopwatch, decodes each to a BCD digit or blank, and publishes a value only once the display has been stable for a programmable number of cycles, filtering multiplex glitches and transitional patterns. Results leave on a valid/ready interface with an overrun flag. Undecodable patterns are reported as errors. Used in benches and on-board self-check logic as the reading end of the display interface.

## Interface
- STABLE_CYCLES, 4, consecutive unchanged edges required before publish; legal range 1..255
- clk100_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- hex0_i..hex3_i  in  7 each  active-low segments {g,f,e,d,c,b,a}, bit0 = a; hex0 = least significant digit
- ready_i  in  1  consumer accepts value_o when high with valid_o
- value_o  out  16  {d3,d2,d1,d0} BCD nibbles; blank digit = 4'hF
- blank_o  out  4  per-digit blank flag (bit n = hexn)
- valid_o  out  1  value_o/blank_o hold an unconsumed result
- overrun_o  out  1  sticky: a result was overwritten before consumption
- err_o  out  1  one-cycle pulse: stable display contains an undecodable pattern
- err_mask_o  out  4  per-digit invalid flags captured with the last err_o
- update_cnt_o  out  16  number of publishes since reset, wraps 16'hFFFF -> 0

## Operation
- Decode table (active-low): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, blank=7'h7F. Any other code is invalid.
- Sample register s_q (28 bits) loads {hex3_i..hex0_i} every edge. Stability counter cnt, 8 bits:
  - input != s_q: cnt <= 0
  - else if cnt != STABLE_CYCLES: cnt <= cnt+1
  - saturates at STABLE_CYCLES
- Publish point is the edge where input == s_q and cnt == STABLE_CYCLES-1. Decode is taken from s_q.
  - All four digits valid or blank, and ({digits,blank} differs from the last publish, or nothing has been published since reset): value_o/blank_o load, valid_o <= 1, update_cnt_o increments.
  - All valid/blank but identical to the last publish: no action.
  - Any digit invalid: err_o pulses 1 cycle, err_mask_o loads the invalid mask, value_o is unchanged.
  - Exactly one publish or error per stable episode. A new episode needs an input change.
- Handshake: valid_o stays high until an edge with valid_o & ready_i, after which it clears.
  - Publish on the same edge as a transfer: new value loads, valid_o stays 1, overrun_o is not set.
  - Publish while valid_o=1 and ready_i=0: value overwritten, overrun_o <= 1. It stays set until reset.
- ready_i is ignored while valid_o=0.

## Timing
- Reset values: value_o=16'h0000, blank_o=4'hF, valid_o=0, overrun_o=0, err_o=0, err_mask_o=0, update_cnt_o=0, s_q=all 7'h7F, cnt=0, published flag cleared.
- A new pattern first present at edge t is published at edge t+STABLE_CYCLES. The pattern must be held for STABLE_CYCLES+1 consecutive edges, and outputs are visible after that edge.
- Any change within that window restarts the count from the changing edge. No partial publish.
- valid_o clears on the edge after ready_i is sampled high. Throughput is one result per STABLE_CYCLES+1 cycles at most.
- Reset mid-episode aborts it. With s_q=blank after reset, an all-blank display still publishes once, because the published flag is cleared.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then hex0..3=7'h40 held for 10 edges, STABLE_CYCLES=4, ready_i=1 -> single valid_o pulse on edge t+4 with value_o=16'h0000, blank_o=0, update_cnt_o=1.
- From the state above, hex0=7'h79 for 3 edges then back to 7'h40 -> no publish. Then hex0=7'h79 held for 5 edges -> value_o=16'h0001, update_cnt_o=2.
- hex2=7'h7E held stable -> err_o high for exactly 1 cycle, err_mask_o=4'b0100, valid_o stays 0, value_o unchanged.
- ready_i=0; publish 16'h0012 then 16'h0013 -> value_o=16'h0013, overrun_o=1. Raise ready_i -> valid_o drops next edge, overrun_o stays 1.
- Stopwatch-style count 0..9 on hex0, each held 6 edges, hex3..1=7'h7F -> 10 publishes, blank_o=4'b1110, value_o=16'hFFF9 last, update_cnt_o=10.
- Assert rst_i when cnt=2 during a pending pattern -> all outputs return to reset values, and a publish requires a fresh STABLE_CYCLES+1 stable edges after release.
